// File: rtl/periph_bus_arbiter_pkg.sv
// periph_bus_arbiter_pkg: shared state encodings, default widths and peripheral register map
package periph_bus_arbiter_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int LED_GPIO_REG = 0;
  localparam int GPIO_HI_REG = 1;
endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; a tie goes to the requester not served last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_srv,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid = |req;
    winner = &req ? ~last_srv : req[1];
  end
endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: shares the single-port peripheral bus between two requesters, one transaction at a time
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] p_addr,
  output logic              p_wr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata
);
  logic [1:0] state;
  logic sel, wr_q, last_srv, valid, winner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  rr_arb2 u_arb (
    .req({req1, req0}),
    .last_srv(last_srv),
    .valid(valid),
    .winner(winner)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      last_srv <= 1'b1;
      rdata <= '0;
    end else begin
      state <= state == IDLE ? (valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
      if (state == IDLE && valid) begin
        sel <= winner;
        last_srv <= winner;
        wr_q <= winner ? wr1 : wr0;
        addr_q <= winner ? addr1 : addr0;
        wdata_q <= winner ? wdata1 : wdata0;
      end
      if (state == ACCESS && !wr_q) rdata <= p_rdata;
    end
  end
  // strobes decode straight from state so an async reset drops them at once
  always_comb begin
    gnt0 = state == ACCESS && !sel;
    gnt1 = state == ACCESS && sel;
    rvalid0 = state == RESP && !sel;
    rvalid1 = state == RESP && sel;
    busy = state != IDLE;
    p_wr = state == ACCESS && wr_q;
    p_addr = addr_q;
    p_wdata = wdata_q;
  end
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: table-driven check of arbitration, handshake timing and reset behaviour
module tb_periph_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic gnt0, rvalid0, gnt1, rvalid1, busy, p_wr;
  logic [31:0] rdata, p_addr, p_wdata, p_rdata;
  logic [31:0] regs [2] = '{32'h0, 32'hDEAD_BEEF};
  int checks = 0, errors = 0;

  periph_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .p_addr(p_addr), .p_wr(p_wr), .p_wdata(p_wdata), .p_rdata(p_rdata)
  );

  always #5 clk = ~clk;

  // peripheral model: two registers, everything else reads as zero
  assign p_rdata = p_addr == 0 ? regs[0] : p_addr == 1 ? regs[1] : 32'h0;
  always @(posedge clk) if (p_wr && p_addr < 2) regs[p_addr[0]] <= p_wdata;

  always @(negedge clk) if (!rst) begin
    checks++;
    if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
      errors++;
      $display("FAIL onehot: gnt=%b%b rvalid=%b%b required not both high", gnt1, gnt0, rvalid1, rvalid0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r0, w0;
    logic [31:0] a0, d0;
    logic r1;
    logic [31:0] a1;
    logic [5:0] ctrl;
    logic [31:0] pa, rd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0, logic r1,
                              logic [31:0] a1, logic [5:0] ctrl, logic [31:0] pa, logic [31:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1;
    v.ctrl = ctrl; v.pa = pa; v.rd = rd;
    return v;
  endfunction

  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] L3FF = 32'h0000_03FF;
  vec_t tbl [29];
  logic [5:0] ctrl_act;
  int gid [4], gcyc [4], n;

  initial begin
    // ctrl = {gnt0, gnt1, rvalid0, rvalid1, p_wr, busy}, sampled just after each edge
    tbl[0]  = mk(1, 1, 0, L3FF, 0, 0, 6'b100011, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 6'b001001, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 1, 6'b000000, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 6'b010001, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 6'b000101, 1, BEEF);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 6'b000000, 1, BEEF);
    tbl[6]  = mk(1, 0, 0, 0, 1, 1, 6'b100001, 0, BEEF);
    tbl[7]  = mk(1, 0, 0, 0, 1, 1, 6'b001001, 0, L3FF);
    tbl[8]  = mk(1, 0, 0, 0, 1, 1, 6'b000000, 0, L3FF);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 6'b010001, 1, L3FF);
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 6'b000101, 1, BEEF);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 6'b000000, 1, BEEF);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 6'b100001, 0, BEEF);
    tbl[13] = mk(1, 0, 0, 0, 1, 1, 6'b001001, 0, L3FF);
    tbl[14] = mk(1, 0, 0, 0, 1, 1, 6'b000000, 0, L3FF);
    tbl[15] = mk(1, 0, 0, 0, 1, 1, 6'b010001, 1, L3FF);
    tbl[16] = mk(1, 0, 0, 0, 1, 1, 6'b000101, 1, BEEF);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 6'b000000, 1, BEEF);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 6'b100001, 0, BEEF);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 6'b001001, 0, L3FF);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 6'b000000, 0, L3FF);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 6'b100001, 0, L3FF);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 6'b001001, 0, L3FF);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 6'b000000, 0, L3FF);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 6'b100001, 0, L3FF);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 6'b001001, 0, L3FF);
    tbl[26] = mk(1, 0, 5, 0, 0, 0, 6'b000000, 0, L3FF);
    tbl[27] = mk(1, 0, 5, 0, 0, 0, 6'b100001, 5, L3FF);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 6'b001001, 5, 0);

    #12;
    chk("reset_ctrl", {26'b0, gnt0, gnt1, rvalid0, rvalid1, p_wr, busy}, 0);
    chk("reset_paddr", p_addr, 0);
    chk("reset_rdata", rdata, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      req0 = tbl[i].r0; wr0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; wr1 = 1'b0; addr1 = tbl[i].a1; wdata1 = 0;
      @(posedge clk); #1;
      ctrl_act = {gnt0, gnt1, rvalid0, rvalid1, p_wr, busy};
      chk($sformatf("v%0d_ctrl", i), {26'b0, ctrl_act}, {26'b0, tbl[i].ctrl});
      chk($sformatf("v%0d_paddr", i), p_addr, tbl[i].pa);
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
      if (i == 1) chk("reg0_after_write", regs[0], L3FF);
      @(negedge clk);
    end

    // reset while a write sits in ACCESS: the write must never land
    req0 = 1; wr0 = 1; addr0 = 1; wdata0 = 32'h1234; req1 = 0;
    n = 0;
    while (!gnt0 && n < 6) begin @(posedge clk); #1; n++; end
    chk("midop_gnt", {31'b0, gnt0}, 1);
    chk("midop_pwr", {31'b0, p_wr}, 1);
    #2 rst = 1'b1;
    #1;
    chk("midop_rst_ctrl", {26'b0, gnt0, gnt1, rvalid0, rvalid1, p_wr, busy}, 0);
    chk("midop_rst_paddr", p_addr, 0);
    chk("midop_rst_rdata", rdata, 0);
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    @(posedge clk); #1;
    chk("midop_reg1", regs[1], BEEF);
    chk("midop_rvalid0", {31'b0, rvalid0}, 0);
    @(negedge clk) rst = 1'b0;

    // contention straight out of reset: grants alternate 0,1,0,1 three cycles apart
    req0 = 1; req1 = 1; addr0 = 0; addr1 = 1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin gid[n] = gnt1 ? 1 : 0; gcyc[n] = c; n++; end
    end
    chk("cont_count", n, 4);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("cont_id%0d", k), gid[k], k % 2);
      chk($sformatf("cont_cyc%0d", k), gcyc[k], 3 * k);
    end
    @(negedge clk) begin req0 = 0; req1 = 0; end
    repeat (3) @(posedge clk);
    #1 chk("final_idle", {31'b0, busy}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
